hack_xalu: RTL and testbench

//  Parametrised, multi-cycle extended ALU for the Hack CPU datapath. Executes all 18

---
 rtl/hack_xalu_if.sv | 25 ++
 rtl/hack_xalu.sv | 181 ++++++++++++++++++
 tb/tb_hack_xalu.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hack_xalu_if.sv
// Request/result bundle for hack_xalu: valid/ready request in, valid-pulse result out.
interface hack_xalu_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [5:0]       control;
  logic             ext;
  logic [1:0]       ext_op;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             busy;

  modport master (
    output in_valid, x, y, control, ext, ext_op,
    input  in_ready, out_valid, out, zr, ng, busy
  );

  modport slave (
    input  in_valid, x, y, control, ext, ext_op,
    output in_ready, out_valid, out, zr, ng, busy
  );
endinterface

// File: rtl/hack_xalu.sv
// Hack ALU with registered result plus iterative MUL, logical SHR and optional DIV/MOD.
// Define HACK_XALU_DIV_EN to build the restoring divider; otherwise DIV/MOD return 0 in one cycle.
module hack_xalu #(
  parameter int WIDTH = 16
) (
  input logic        clk,
  input logic        rst,
  hack_xalu_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

`ifdef HACK_XALU_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // MUL: acc=product, a=shifting multiplicand, b=shifting multiplier.
  // DIV: acc=remainder, a=divisor, b=dividend shifting into quotient.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res;
  logic             wr;
`ifdef HACK_XALU_DIV_EN
  logic             mod_q, mod_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
`endif

  function automatic logic [WIDTH-1:0] hack_op(input logic [WIDTH-1:0] xa,
                                               input logic [WIDTH-1:0] ya,
                                               input logic [5:0]       c);
    logic [WIDTH-1:0] x1, x2, y1, y2, r;
    x1 = c[5] ? '0 : xa;
    x2 = c[4] ? ~x1 : x1;
    y1 = c[3] ? '0 : ya;
    y2 = c[2] ? ~y1 : y1;
    r  = c[1] ? x2 + y2 : x2 & y2;
    return c[0] ? ~r : r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    vld_d   = 1'b0;
    res     = '0;
    wr      = 1'b0;
`ifdef HACK_XALU_DIV_EN
    mod_d   = mod_q;
    rem_sh  = '0;
    diff    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (!bus.ext) begin
            res = hack_op(bus.x, bus.y, bus.control);
            wr  = 1'b1;
          end else begin
            case (bus.ext_op)
              2'b00: begin
                state_d = S_MUL;
                cnt_d   = '0;
                acc_d   = '0;
                a_d     = bus.x;
                b_d     = bus.y;
              end
              2'b11: begin
                res = bus.x >> bus.y[SW-1:0];
                wr  = 1'b1;
              end
              default: begin
`ifdef HACK_XALU_DIV_EN
                state_d = S_DIV;
                cnt_d   = '0;
                acc_d   = '0;
                a_d     = bus.y;
                b_d     = bus.x;
                mod_d   = bus.ext_op[1];
`else
                res = '0;
                wr  = 1'b1;
`endif
              end
            endcase
          end
        end
      end
      S_MUL: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_LAST) begin
          res     = acc_d;
          wr      = 1'b1;
          state_d = S_IDLE;
        end
      end
`ifdef HACK_XALU_DIV_EN
      S_DIV: begin
        // Divide by zero falls out naturally: every trial subtract succeeds.
        rem_sh = {acc_q, b_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, a_q};
        if (rem_sh >= {1'b0, a_q}) begin
          acc_d = diff[WIDTH-1:0];
          b_d   = {b_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = rem_sh[WIDTH-1:0];
          b_d   = {b_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_LAST) begin
          res     = mod_q ? acc_d : b_d;
          wr      = 1'b1;
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (wr) begin
      out_d = res;
      zr_d  = (res == '0);
      ng_d  = res[WIDTH-1];
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
      vld_q   <= 1'b0;
`ifdef HACK_XALU_DIV_EN
      mod_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
      vld_q   <= vld_d;
`ifdef HACK_XALU_DIV_EN
      mod_q   <= mod_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = vld_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
endmodule

// File: tb/tb_hack_xalu.sv
// Randomized self-checking bench for hack_xalu (WIDTH=16) against an arithmetic reference model.
module tb_hack_xalu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hack_xalu_if #(.WIDTH(16)) b();
  hack_xalu #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: Hack rules with plain integer arithmetic (complement = 0xFFFF - v).
  function automatic logic [15:0] ref_hack(input int xv, input int yv, input logic [5:0] c);
    int a, bb, r;
    a  = c[5] ? 0 : xv;
    if (c[4]) a = 65535 - a;
    bb = c[3] ? 0 : yv;
    if (c[2]) bb = 65535 - bb;
    r  = c[1] ? (a + bb) % 65536 : (a & bb);
    if (c[0]) r = 65535 - r;
    return 16'(r);
  endfunction

  function automatic logic [15:0] ref_model(input logic [15:0] xv, input logic [15:0] yv,
                                            input logic [5:0] c, input logic e, input logic [1:0] op);
    int ux, uy;
    ux = int'(xv);
    uy = int'(yv);
    if (!e) return ref_hack(ux, uy, c);
    case (op)
      2'b00: return 16'((ux * uy) % 65536);
`ifdef HACK_XALU_DIV_EN
      2'b01: return (uy == 0) ? 16'hFFFF : 16'(ux / uy);
      2'b10: return (uy == 0) ? xv : 16'(ux % uy);
`else
      2'b01, 2'b10: return 16'h0000;
`endif
      default: return 16'(ux / (1 << (uy % 16)));
    endcase
  endfunction

  function automatic int ref_lat(input logic e, input logic [1:0] op);
    if (!e || op == 2'b11) return 1;
    if (op == 2'b00) return 17;
`ifdef HACK_XALU_DIV_EN
    return 17;
`else
    return 1;
`endif
  endfunction

  task automatic drive(input logic [15:0] xv, input logic [15:0] yv, input logic [5:0] c,
                       input logic e, input logic [1:0] op);
    b.in_valid = 1'b1;
    b.x = xv; b.y = yv; b.control = c; b.ext = e; b.ext_op = op;
  endtask

  task automatic run_op(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                        input logic [5:0] c, input logic e, input logic [1:0] op);
    logic [15:0] exp;
    int lat, n, busy_n;
    exp = ref_model(xv, yv, c, e, op);
    lat = ref_lat(e, op);
    @(negedge clk);
    check({tag, ":rdy"}, 32'(b.in_ready), 32'd1);
    drive(xv, yv, c, e, op);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    n = 0; busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b.out_valid) begin n = i; break; end
      if (b.busy) busy_n++;
    end
    check({tag, ":lat"}, 32'(n), 32'(lat));
    check({tag, ":busy"}, 32'(busy_n), 32'(lat - 1));
    check({tag, ":out"}, 32'(b.out), 32'(exp));
    check({tag, ":zr"}, 32'(b.zr), 32'(exp == 16'd0));
    check({tag, ":ng"}, 32'(b.ng), 32'(exp[15]));
    @(negedge clk);
    check({tag, ":pulse"}, 32'(b.out_valid), 32'd0);
    check({tag, ":hold"}, 32'(b.out), 32'(exp));
  endtask

  logic [5:0] enc [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                           6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                           6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  // Canonical Hack meaning of each encoding, with x as D and y as A.
  function automatic logic [15:0] canon(input int k, input logic [15:0] d, input logic [15:0] a);
    case (k)
      0: return 16'd0;       1: return 16'd1;       2: return 16'hFFFF;
      3: return d;           4: return a;           5: return ~d;
      6: return ~a;          7: return -d;          8: return -a;
      9: return d + 16'd1;   10: return a + 16'd1;  11: return d - 16'd1;
      12: return a - 16'd1;  13: return d + a;      14: return d - a;
      15: return a - d;      16: return d & a;      default: return d | a;
    endcase
  endfunction

  initial begin
    int pulses;
    logic [15:0] rx, ry;
    b.in_valid = 1'b0; b.x = '0; b.y = '0; b.control = '0; b.ext = 1'b0; b.ext_op = '0;
    repeat (2) @(negedge clk);
    check("rst:out", 32'(b.out), 32'd0);
    check("rst:zr", 32'(b.zr), 32'd0);
    check("rst:ng", 32'(b.ng), 32'd0);
    check("rst:vld", 32'(b.out_valid), 32'd0);
    check("rst:rdy", 32'(b.in_ready), 32'd1);
    check("rst:busy", 32'(b.busy), 32'd0);
    rst = 1'b0;

    run_op("dpa", 16'd5, 16'd3, 6'b000010, 1'b0, 2'b00);
    check("dpa:val", 32'(b.out), 32'd8);
    run_op("dma", 16'd5, 16'd3, 6'b010011, 1'b0, 2'b00);
    check("dma:val", 32'(b.out), 32'd2);
    run_op("amd", 16'd5, 16'd3, 6'b000111, 1'b0, 2'b00);
    check("amd:val", 32'(b.out), 32'hFFFE);
    run_op("zero", 16'd5, 16'd3, 6'b101010, 1'b0, 2'b00);
    check("zero:zr", 32'(b.zr), 32'd1);

    for (int k = 0; k < 18; k++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      run_op($sformatf("enc%0d", k), rx, ry, enc[k], 1'b0, 2'b00);
      check($sformatf("enc%0d:canon", k), 32'(b.out), 32'(canon(k, rx, ry)));
    end

    run_op("mul", 16'd300, 16'd300, 6'd0, 1'b1, 2'b00);
    check("mul:val", 32'(b.out), 32'h5F90);
    run_op("div", 16'd100, 16'd7, 6'd0, 1'b1, 2'b01);
    run_op("mod", 16'd100, 16'd7, 6'd0, 1'b1, 2'b10);
`ifdef HACK_XALU_DIV_EN
    check("mod:val", 32'(b.out), 32'd2);
`else
    check("div0:val", 32'(b.out), 32'd0);
`endif
    run_op("div0", 16'd9, 16'd0, 6'd0, 1'b1, 2'b01);
    run_op("mod0", 16'd9, 16'd0, 6'd0, 1'b1, 2'b10);
    run_op("shr", 16'h8000, 16'h0013, 6'd0, 1'b1, 2'b11);
    check("shr:val", 32'(b.out), 32'h1000);

    // Back-to-back single-cycle ops: SHR then D+1.
    @(negedge clk);
    drive(16'h8000, 16'h0013, 6'd0, 1'b1, 2'b11);
    @(posedge clk);
    #1 drive(16'd41, 16'd0, 6'b011111, 1'b0, 2'b00);
    @(negedge clk);
    check("b2b:v1", 32'(b.out_valid), 32'd1);
    check("b2b:o1", 32'(b.out), 32'h1000);
    check("b2b:rdy", 32'(b.in_ready), 32'd1);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    @(negedge clk);
    check("b2b:v2", 32'(b.out_valid), 32'd1);
    check("b2b:o2", 32'(b.out), 32'd42);
    @(negedge clk);
    check("b2b:v3", 32'(b.out_valid), 32'd0);

    // in_valid held with fresh operands during MUL must be ignored.
    @(negedge clk);
    drive(16'd7, 16'd9, 6'd0, 1'b1, 2'b00);
    @(posedge clk);
    #1 drive(16'd1234, 16'd55, 6'b000010, 1'b0, 2'b00);
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (b.out_valid) begin
        pulses++;
        check("ign:out", 32'(b.out), 32'd63);
        b.in_valid = 1'b0;
      end
    end
    check("ign:pulses", 32'(pulses), 32'd1);

    // Reset in the middle of a MUL aborts it.
    @(negedge clk);
    drive(16'd300, 16'd300, 6'd0, 1'b1, 2'b00);
    @(posedge clk);
    #1 b.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #2;
    check("abort:out", 32'(b.out), 32'd0);
    check("abort:zr", 32'(b.zr), 32'd0);
    check("abort:vld", 32'(b.out_valid), 32'd0);
    check("abort:rdy", 32'(b.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b.out_valid) pulses++;
    end
    check("abort:none", 32'(pulses), 32'd0);
    run_op("post", 16'd5, 16'd3, 6'b000010, 1'b0, 2'b00);
    check("post:val", 32'(b.out), 32'd8);

    // Random mix of all op kinds.
    for (int t = 0; t < 60; t++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      if (t % 4 == 0) ry = 16'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", t), rx, ry, 6'($urandom), 1'($urandom), 2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
